mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter_rr_arbiter.sv | 45 ++++
 rtl/mem_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared state encoding, size encodings and IO decode constant for mem_arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } arb_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Address bits [17:16] equal to this select the IO window.
  localparam logic [1:0] IO_SEL = 2'b11;
  localparam int         MEM_AW = 18;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_arbiter.sv
// Round-robin grant: search starts one channel after the last advanced grant.
module rr_arbiter #(
  parameter int NPORT = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [NPORT-1:0] req,
  input  logic             advance,
  output logic [NPORT-1:0] grant
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] win;
  logic [IW:0]   t;
  logic          found;

  always_comb begin
    grant = '0;
    win   = last_q;
    found = 1'b0;
    t     = '0;
    for (int i = 1; i <= NPORT; i++) begin
      t = {1'b0, last_q} + (IW+1)'(i);
      if (t >= (IW+1)'(NPORT)) t = t - (IW+1)'(NPORT);
      for (int p = 0; p < NPORT; p++) begin
        if (!found && req[p] && (t == (IW+1)'(p))) begin
          found    = 1'b1;
          grant[p] = 1'b1;
          win      = IW'(p);
        end
      end
    end
  end

  assign last_d = (advance && found) ? win : last_q;

  // Resetting to the top channel makes channel 0 the first winner.
  always_ff @(posedge clk_in) begin
    if (!rst_in) last_q <= IW'(NPORT - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NPORT byte/half/word requests onto an 8-bit memory.
// Optional IO write guard (buffer-full hold plus idle gap) with MEM_ARBITER_IO_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NPORT  = 2,
  parameter int ADDR_W = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT-1:0]        req_wr,
  input  logic [2*NPORT-1:0]      req_size,
  input  logic [ADDR_W*NPORT-1:0] req_addr,
  input  logic [32*NPORT-1:0]     req_wdata,
  output logic [NPORT-1:0]        req_ready,
  output logic [NPORT-1:0]        resp_valid,
  output logic [31:0]             resp_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    io_buffer_full
);

  // state   | meaning
  // IDLE    | arbitrate, latch winning request
  // RD      | address bytes 0..N-1, capture each one cycle later
  // WR      | drive one byte per cycle
  // DONE    | one-cycle resp_valid to the granted channel
  arb_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nb_q, nb_d;
  logic              wr_q, wr_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [NPORT-1:0]  gnt_q, gnt_d;
  logic              resume_q, resume_d;
  logic              gap_q, gap_d;

  logic [NPORT-1:0]  grant;
  logic              advance;
  logic [2:0]        byte_idx;
  logic [2:0]        prev_idx;
  logic [MEM_AW-1:0] byte_addr;
  logic              is_io, io_hold, io_gap_en;
  logic [ADDR_W*NPORT-1:0] unused_addr;

  rr_arbiter #(.NPORT(NPORT)) u_rr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant)
  );

  assign unused_addr = req_addr;
  assign is_io       = (addr_q[17:16] == IO_SEL);
  assign prev_idx    = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;

`ifdef MEM_ARBITER_IO_GUARD_EN
  assign io_gap_en = is_io;
  assign io_hold   = is_io && (gap_q || io_buffer_full);
`else
  logic unused_io;
  assign io_gap_en = 1'b0;
  assign io_hold   = 1'b0;
  assign unused_io = ^{io_buffer_full, is_io};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    nb_d       = nb_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    gnt_d      = gnt_q;
    resume_d   = resume_q;
    gap_d      = gap_q;
    advance    = 1'b0;
    req_ready  = '0;
    resp_valid = '0;
    mem_wr     = 1'b0;
    mem_dout   = '0;
    byte_idx   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (rdy_in && (|grant)) begin
          advance   = 1'b1;
          req_ready = grant;
          gnt_d     = grant;
          cnt_d     = '0;
          rdata_d   = '0;
          resume_d  = 1'b0;
          gap_d     = 1'b0;
          for (int p = 0; p < NPORT; p++) begin
            if (grant[p]) begin
              wr_d    = req_wr[p];
              nb_d    = size_bytes(req_size[2*p +: 2]);
              addr_d  = req_addr[ADDR_W*p +: MEM_AW];
              wdata_d = req_wdata[32*p +: 32];
            end
          end
          state_d = wr_d ? ST_WR : ST_RD;
        end
      end

      ST_RD: begin
        // While paused, resuming, or on the capture-only last cycle, keep the in-flight byte addressed.
        if (resume_q || !rdy_in || (cnt_q == nb_q)) byte_idx = prev_idx;
        if (!rdy_in) begin
          resume_d = 1'b1;
        end else if (resume_q) begin
          resume_d = 1'b0;
        end else begin
          if (cnt_q != 3'd0) rdata_d[{prev_idx[1:0], 3'b000} +: 8] = mem_din;
          if (cnt_q == nb_q) state_d = ST_DONE;
          else               cnt_d   = cnt_q + 3'd1;
        end
      end

      ST_WR: begin
        if (cnt_q == nb_q) byte_idx = prev_idx;
        if (rdy_in) begin
          if (io_hold) begin
            if (gap_q) begin
              gap_d = 1'b0;
              if (cnt_q == nb_q) state_d = ST_DONE;
            end
          end else begin
            mem_wr   = 1'b1;
            mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
            cnt_d    = cnt_q + 3'd1;
            gap_d    = io_gap_en;
            if (((cnt_q + 3'd1) == nb_q) && !io_gap_en) state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (rdy_in) begin
          resp_valid = gnt_q;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (!rst_in) begin
      advance    = 1'b0;
      req_ready  = '0;
      resp_valid = '0;
      mem_wr     = 1'b0;
      mem_dout   = '0;
    end
  end

  assign byte_addr  = addr_q + MEM_AW'(byte_idx);
  assign mem_a      = (rst_in && ((state_q == ST_RD) || (state_q == ST_WR)))
                      ? {{(32-MEM_AW){1'b0}}, byte_addr} : '0;
  assign resp_rdata = (rst_in && (state_q == ST_DONE) && !wr_q) ? rdata_q : '0;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      nb_q     <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      resume_q <= 1'b0;
      gap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nb_q     <= nb_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      gnt_q    <= gnt_d;
      resume_q <= resume_d;
      gap_q    <= gap_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with two channels and a byte-wide synchronous memory model.
module tb_mem_arbiter;

  localparam int NPORT  = 2;
  localparam int ADDR_W = 32;

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] data;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    rdy_in;
  logic [NPORT-1:0]        req_valid;
  logic [NPORT-1:0]        req_wr;
  logic [2*NPORT-1:0]      req_size;
  logic [ADDR_W*NPORT-1:0] req_addr;
  logic [32*NPORT-1:0]     req_wdata;
  logic [NPORT-1:0]        req_ready;
  logic [NPORT-1:0]        resp_valid;
  logic [31:0]             resp_rdata;
  logic [7:0]              mem_din;
  logic [7:0]              mem_dout;
  logic [31:0]             mem_a;
  logic                    mem_wr;
  logic                    io_buffer_full;

  logic [7:0] mem [0:262143];
  resp_t exp_resp[$];
  wr_t   exp_wr[$];
  int    grant_log[$];
  int    grant_cyc[NPORT];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  resp_t r;
  wr_t   w;

  mem_arbiter #(.NPORT(NPORT), .ADDR_W(ADDR_W)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .req_valid      (req_valid),
    .req_wr         (req_wr),
    .req_size       (req_size),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    mem_din <= mem[mem_a[17:0]];
    if (mem_wr) mem[mem_a[17:0]] <= mem_dout;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < NPORT; c++) begin
        if (req_ready[c]) begin
          grant_cyc[c] = cyc;
          grant_log.push_back(c);
        end
      end
      if (mem_wr) begin
        check_eq("wr_pending", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          w = exp_wr.pop_front();
          check_eq("wr_addr", mem_a, w.a);
          check_eq("wr_data", 32'(mem_dout), 32'(w.d));
        end
`ifdef MEM_ARBITER_IO_GUARD_EN
        if (mem_a[17:16] == 2'b11) check_eq("io_full_wr", 32'(io_buffer_full), 32'd0);
`endif
      end
      for (int c = 0; c < NPORT; c++) begin
        if (resp_valid[c]) begin
          check_eq("resp_pending", 32'(exp_resp.size() != 0), 32'd1);
          if (exp_resp.size() != 0) begin
            r = exp_resp.pop_front();
            check_eq("resp_chan", 32'(c), 32'(r.ch));
            if (!r.wr) check_eq("resp_data", resp_rdata, r.data);
            if (r.lat >= 0) check_eq("resp_lat", 32'(cyc - grant_cyc[c]), 32'(r.lat));
          end
        end
      end
    end
  end

  task automatic expect_resp(input int ch, input bit wr, input logic [31:0] data, input int lat);
    resp_t e;
    e.ch = ch; e.wr = wr; e.data = data; e.lat = lat;
    exp_resp.push_back(e);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a; e.d = d;
    exp_wr.push_back(e);
  endtask

  task automatic set_fields(input int ch, input logic wr, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
    req_wr[ch]              = wr;
    req_size[2*ch +: 2]     = size;
    req_addr[32*ch +: 32]   = addr;
    req_wdata[32*ch +: 32]  = wdata;
  endtask

  // Returns #1 after the edge that accepts the request (first transfer cycle).
  task automatic issue(input int ch, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    bit got;
    got = 1'b0;
    set_fields(ch, wr, size, addr, wdata);
    req_valid[ch] = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk_in);
      if (req_ready[ch]) got = 1'b1;
    end
    check_eq("grant_wait", 32'(got), 32'd1);
    @(posedge clk_in);
    #1 req_valid[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (exp_resp.size() != 0 && i < 300) begin
      @(negedge clk_in);
      i++;
    end
    check_eq("resp_drain", 32'(exp_resp.size()), 32'd0);
    check_eq("wr_drain", 32'(exp_wr.size()), 32'd0);
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
    req_valid = '1; req_wr = '0; req_size = '0; req_addr = '0; req_wdata = '0;
    mem[18'h100] = 8'h11; mem[18'h101] = 8'h22; mem[18'h102] = 8'h33; mem[18'h103] = 8'h44;

    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_rdata", resp_rdata, 32'd0);
    check_eq("rst_mem_dout", 32'(mem_dout), 32'd0);
    check_eq("rst_mem_a", mem_a, 32'd0);
    check_eq("rst_mem_wr", 32'(mem_wr), 32'd0);
    req_valid = '0;
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;

    expect_resp(0, 0, 32'h44332211, 6);
    issue(0, 1'b0, 2'd2, 32'h100, 32'h0);
    wait_idle();

    expect_wr(32'h200, 8'hEF); expect_wr(32'h201, 8'hBE);
    expect_resp(1, 1, 32'h0, 3);
    issue(1, 1'b1, 2'd1, 32'h200, 32'h0000BEEF);
    wait_idle();

    expect_resp(1, 0, 32'h000000BE, 3);
    issue(1, 1'b0, 2'd0, 32'h201, 32'h0);
    wait_idle();

    expect_resp(0, 0, 32'h00002211, 4);
    issue(0, 1'b0, 2'd1, 32'h100, 32'h0);
    wait_idle();

    expect_resp(1, 0, 32'h44332211, 6);
    issue(1, 1'b0, 2'd3, 32'h100, 32'h0);
    wait_idle();

    expect_wr(32'h300, 8'h78); expect_wr(32'h301, 8'h56);
    expect_wr(32'h302, 8'h34); expect_wr(32'h303, 8'h12);
    expect_resp(0, 1, 32'h0, 5);
    issue(0, 1'b1, 2'd2, 32'h300, 32'h12345678);
    wait_idle();
    expect_resp(1, 0, 32'h12345678, 6);
    issue(1, 1'b0, 2'd2, 32'h300, 32'h0);
    wait_idle();

    // Pause for three cycles on transfer cycle 2 of a word read.
    expect_resp(0, 0, 32'h44332211, 10);
    issue(0, 1'b0, 2'd2, 32'h100, 32'h0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rdy_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rdy_in = 1'b1;
    wait_idle();

    // IO byte write with the UART buffer full on the first four transfer cycles.
    io_buffer_full = 1'b1;
`ifdef MEM_ARBITER_IO_GUARD_EN
    expect_resp(0, 1, 32'h0, 7);
`else
    expect_resp(0, 1, 32'h0, 2);
`endif
    expect_wr(32'h30000, 8'h41);
    issue(0, 1'b1, 2'd0, 32'h30000, 32'h41);
    repeat (4) @(posedge clk_in);
    #1 io_buffer_full = 1'b0;
    wait_idle();

    // A request withdrawn while the arbiter is busy is never granted.
    base = grant_log.size();
    expect_resp(0, 0, 32'h44332211, 6);
    issue(0, 1'b0, 2'd2, 32'h100, 32'h0);
    set_fields(1, 1'b0, 2'd2, 32'h300, 32'h0);
    req_valid[1] = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 req_valid[1] = 1'b0;
    wait_idle();
    repeat (10) @(posedge clk_in);
    #1;
    check_eq("drop_grants", 32'(grant_log.size() - base), 32'd1);

    // Reset on cycle 2 of a channel 0 word write.
    expect_wr(32'h400, 8'h0D); expect_wr(32'h401, 8'hF0);
    issue(0, 1'b1, 2'd2, 32'h400, 32'hCAFEF00D);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(posedge clk_in);
    @(negedge clk_in);
    check_eq("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    check_eq("rst_mid_resp", 32'(resp_valid), 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    check_eq("rst_mid_wr_drain", 32'(exp_wr.size()), 32'd0);

    // Both channels request continuously; order must rotate starting at channel 0.
    base = grant_log.size();
    expect_resp(0, 0, 32'h44332211, 6);
    expect_resp(1, 1, 32'h0, 3);
    expect_resp(0, 0, 32'h44332211, 6);
    expect_resp(1, 1, 32'h0, 3);
    expect_wr(32'h200, 8'hEF); expect_wr(32'h201, 8'hBE);
    expect_wr(32'h200, 8'hEF); expect_wr(32'h201, 8'hBE);
    set_fields(0, 1'b0, 2'd2, 32'h100, 32'h0);
    set_fields(1, 1'b1, 2'd1, 32'h200, 32'h0000BEEF);
    req_valid = 2'b11;
    for (int i = 0; i < 400 && grant_log.size() < base + 4; i++) @(negedge clk_in);
    @(posedge clk_in);
    #1 req_valid = '0;
    check_eq("rr_grants", 32'(grant_log.size() - base), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < grant_log.size()) check_eq("rr_order", 32'(grant_log[base + k]), 32'(k % 2));
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
